// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register for the 5-stage MIPS pipeline with
//            built-in load-use hazard detection, branch-flush bubbling,
//            memory-stall freeze and a saturating load-use bubble counter.
// Ports    : clk, rst_n           - clock, async active-low reset
//            id_*                 - decoded instruction from ID
//            flush, mem_stall     - redirect squash / global freeze
//            ex_*                 - registered instruction presented to EX
//            ex_wreg, ex_fw       - destination register and write qualifier
//            load_use_stall       - combinational hazard stall request
//            pc_write, if_id_write- PC and IF/ID enables
//            bubble_cnt           - saturating count of load-use bubbles
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             ex_valid,
  output logic [5:0]       ex_opcode,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [31:0]      ex_rs_data,
  output logic [31:0]      ex_rt_data,
  output logic [31:0]      ex_imm,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic [4:0]       ex_wreg,
  output logic             ex_fw,
  output logic             load_use_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic             ex_valid_q, ex_valid_d;
  logic [5:0]       ex_opcode_q, ex_opcode_d;
  logic [4:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_wreg_q, ex_wreg_d;
  logic [31:0]      ex_rs_data_q, ex_rs_data_d;
  logic [31:0]      ex_rt_data_q, ex_rt_data_d;
  logic [31:0]      ex_imm_q, ex_imm_d;
  logic             ex_alusrc_q, ex_alusrc_d, ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d, ex_memwrite_q, ex_memwrite_d;
  logic             ex_memtoreg_q, ex_memtoreg_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic id_reads_rt;
  logic hz;

  // Only R-type, store and the two compare branches consume rt as a source;
  // for every other opcode rt is a destination and cannot cause a hazard.
  assign id_reads_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
                       (id_opcode == OP_BEQ)   || (id_opcode == OP_BNE);

  assign hz = ex_valid_q && ex_memread_q && (ex_rt_q != 5'd0) && id_valid &&
              ((id_rs == ex_rt_q) || (id_reads_rt && (id_rt == ex_rt_q)));

  assign load_use_stall = hz && !flush && !mem_stall;
  assign pc_write       = !mem_stall && !load_use_stall;
  assign if_id_write    = pc_write;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_opcode_d   = ex_opcode_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_rs_data_d  = ex_rs_data_q;
    ex_rt_data_d  = ex_rt_data_q;
    ex_imm_d      = ex_imm_q;
    ex_alusrc_d   = ex_alusrc_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    ex_memtoreg_d = ex_memtoreg_q;
    ex_wreg_d     = ex_wreg_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (!mem_stall) begin
      // Flush, load-use stall and an empty ID slot all load the same bubble.
      if (flush || hz || !id_valid) begin
        ex_valid_d    = 1'b0;
        ex_opcode_d   = 6'd0;
        ex_rs_d       = 5'd0;
        ex_rt_d       = 5'd0;
        ex_rs_data_d  = 32'd0;
        ex_rt_data_d  = 32'd0;
        ex_imm_d      = 32'd0;
        ex_alusrc_d   = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        ex_memtoreg_d = 1'b0;
        ex_wreg_d     = 5'd0;
      end else begin
        ex_valid_d    = 1'b1;
        ex_opcode_d   = id_opcode;
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
        ex_rs_data_d  = id_rs_data;
        ex_rt_data_d  = id_rt_data;
        ex_imm_d      = id_imm;
        ex_alusrc_d   = id_alusrc;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
        ex_memwrite_d = id_memwrite;
        ex_memtoreg_d = id_memtoreg;
        ex_wreg_d     = id_regdst ? id_rd : id_rt;
      end
      if (load_use_stall && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_opcode_q   <= 6'd0;
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_rs_data_q  <= 32'd0;
      ex_rt_data_q  <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_alusrc_q   <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_memtoreg_q <= 1'b0;
      ex_wreg_q     <= 5'd0;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_memtoreg_q <= ex_memtoreg_d;
      ex_wreg_q     <= ex_wreg_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_alusrc   = ex_alusrc_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign ex_memwrite = ex_memwrite_q;
  assign ex_memtoreg = ex_memtoreg_q;
  assign ex_wreg     = ex_wreg_q;
  assign ex_fw       = ex_valid_q && ex_regwrite_q && (ex_wreg_q != 5'd0);
  assign bubble_cnt  = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. A main instance (CNT_W=16)
//            and a narrow-counter instance (CNT_W=2) share all inputs.
//            Expected values come from an EX-slot model built from the
//            pipeline rules (hazard, priority, bubble, saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic flush, mem_stall;

  logic ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_fw;
  logic [5:0] ex_opcode;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic load_use_stall, pc_write, if_id_write;
  logic [15:0] bubble_cnt;

  logic s_valid, s_alusrc, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_fw;
  logic [5:0] s_opcode;
  logic [4:0] s_rs, s_rt, s_wreg;
  logic [31:0] s_rs_data, s_rt_data, s_imm;
  logic s_lus, s_pcw, s_ifw;
  logic [1:0] s_cnt;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .flush(flush),
    .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_wreg(ex_wreg), .ex_fw(ex_fw), .load_use_stall(load_use_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .flush(flush),
    .mem_stall(mem_stall), .ex_valid(s_valid), .ex_opcode(s_opcode),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data),
    .ex_imm(s_imm), .ex_alusrc(s_alusrc), .ex_regwrite(s_regwrite),
    .ex_memread(s_memread), .ex_memwrite(s_memwrite), .ex_memtoreg(s_memtoreg),
    .ex_wreg(s_wreg), .ex_fw(s_fw), .load_use_stall(s_lus),
    .pc_write(s_pcw), .if_id_write(s_ifw), .bubble_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        alusrc, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  wreg;
  } slot_t;

  slot_t m;            // what the EX slot should contain
  slot_t obs;
  int    m_cnt, m_cnt2;
  int    n_vec = 0;
  int    n_err = 0;

  assign obs = {ex_valid, ex_opcode, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm,
                ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_wreg};

  // ---------------- reference model ----------------
  function automatic logic model_hz();
    logic reads_rt;
    reads_rt = (id_opcode == 6'h00) || (id_opcode == 6'h2B) ||
               (id_opcode == 6'h04) || (id_opcode == 6'h05);
    return m.valid && m.memread && (m.rt != 0) && id_valid &&
           ((id_rs == m.rt) || (reads_rt && (id_rt == m.rt)));
  endfunction

  function automatic logic model_lus();
    return model_hz() && !flush && !mem_stall;
  endfunction

  function automatic logic model_fw();
    return m.valid && m.regwrite && (m.wreg != 0);
  endfunction

  task automatic model_edge();
    if (mem_stall) begin
      // frozen
    end else if (flush) begin
      m = '0;
    end else if (model_hz()) begin
      m = '0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (!id_valid) begin
      m = '0;
    end else begin
      m.valid = 1'b1;      m.opcode = id_opcode;
      m.rs = id_rs;        m.rt = id_rt;
      m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
      m.alusrc = id_alusrc; m.regwrite = id_regwrite; m.memread = id_memread;
      m.memwrite = id_memwrite; m.memtoreg = id_memtoreg;
      m.wreg = id_regdst ? id_rd : id_rt;
    end
  endtask

  task automatic model_reset();
    m = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic regdst,
                        input logic rw, input logic asrc, input logic mr,
                        input logic mw, input logic m2r);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regdst = regdst; id_regwrite = rw; id_alusrc = asrc;
    id_memread = mr; id_memwrite = mw; id_memtoreg = m2r;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic drive_lw(input logic [4:0] base, input logic [4:0] dst);
    set_id(1, 6'h23, base, dst, 5'($urandom), 0, 1, 1, 1, 0, 1);
  endtask
  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, 6'h00, rs, rt, rd, 1, 1, 0, 0, 0, 0);
  endtask
  task automatic drive_addi(input logic [4:0] rt, input logic [4:0] rs);
    set_id(1, 6'h08, rs, rt, 5'($urandom), 0, 1, 1, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    set_id(1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (obs !== '0) begin n_err++; $display("FAIL reset_ex: got %h want 0", obs); end
    n_vec++; if (bubble_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    n_vec++; if ({load_use_stall, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL reset_ctl: got %b want 011", {load_use_stall, pc_write, if_id_write}); end
    @(negedge clk); rst_n = 1'b1;
    drive_add(5'd3, 5'd1, 5'd2);
    tick();
    n_vec++; if (ex_wreg !== 5'd3 || ex_fw !== 1'b1 || ex_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_first_add: got wreg=%0d fw=%b v=%b want 3 1 1", ex_wreg, ex_fw, ex_valid); end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    drive_lw(5'd1, 5'd5); tick();
    drive_add(5'd6, 5'd5, 5'd2); #1;
    n_vec++; if ({load_use_stall, pc_write, if_id_write} !== 3'b100) begin
      n_err++; $display("FAIL lu_stall: got %b want 100", {load_use_stall, pc_write, if_id_write}); end
    tick();
    n_vec++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || bubble_cnt !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL lu_bubble: got v=%b mr=%b cnt=%0d want 0 0 %0d", ex_valid, ex_memread, bubble_cnt, c0 + 1); end
    n_vec++; if ({load_use_stall, pc_write} !== 2'b01) begin
      n_err++; $display("FAIL lu_release: got %b want 01", {load_use_stall, pc_write}); end
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd6 || ex_rs !== 5'd5 || ex_opcode !== 6'h00) begin
      n_err++; $display("FAIL lu_issue: got v=%b wreg=%0d rs=%0d want 1 6 5", ex_valid, ex_wreg, ex_rs); end
  endtask

  task automatic test_no_false_hazard();
    drive_lw(5'd1, 5'd5); tick();
    drive_addi(5'd5, 5'd7); #1;
    n_vec++; if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
      n_err++; $display("FAIL nofalse_itype: got lus=%b pcw=%b want 0 1", load_use_stall, pc_write); end
    drive_lw(5'd1, 5'd0); tick();
    drive_add(5'd6, 5'd0, 5'd0); #1;
    n_vec++; if (load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL nofalse_r0: got lus=%b want 0", load_use_stall); end
    tick();
    n_vec++; if (obs !== m) begin n_err++; $display("FAIL nofalse_capture: got %h want %h", obs, m); end
  endtask

  task automatic test_flush_priority();
    int c0;
    c0 = m_cnt;
    drive_lw(5'd1, 5'd5); tick();
    drive_add(5'd6, 5'd5, 5'd2); flush = 1'b1; #1;
    n_vec++; if ({load_use_stall, pc_write, if_id_write} !== 3'b011) begin
      n_err++; $display("FAIL flush_ctl: got %b want 011", {load_use_stall, pc_write, if_id_write}); end
    tick(); flush = 1'b0;
    n_vec++; if (ex_valid !== 1'b0 || obs !== '0 || bubble_cnt !== 16'(c0)) begin
      n_err++; $display("FAIL flush_bubble: got v=%b cnt=%0d want 0 %0d", ex_valid, bubble_cnt, c0); end
  endtask

  task automatic test_mem_stall();
    slot_t held;
    int c0;
    drive_lw(5'd1, 5'd5); tick();
    held = m; c0 = m_cnt;
    drive_add(5'd6, 5'd5, 5'd2); mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({load_use_stall, pc_write, if_id_write} !== 3'b000) begin
        n_err++; $display("FAIL mstall_ctl[%0d]: got %b want 000", i, {load_use_stall, pc_write, if_id_write}); end
      tick();
      n_vec++; if (obs !== held || bubble_cnt !== 16'(c0)) begin
        n_err++; $display("FAIL mstall_hold[%0d]: got %h cnt=%0d want %h %0d", i, obs, bubble_cnt, held, c0); end
    end
    mem_stall = 1'b0; #1;
    n_vec++; if (load_use_stall !== 1'b1) begin
      n_err++; $display("FAIL mstall_refire: got lus=%b want 1", load_use_stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b0 || bubble_cnt !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL mstall_count: got v=%b cnt=%0d want 0 %0d", ex_valid, bubble_cnt, c0 + 1); end
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd6) begin
      n_err++; $display("FAIL mstall_issue: got v=%b wreg=%0d want 1 6", ex_valid, ex_wreg); end
  endtask

  task automatic test_reset_mid_stall();
    drive_lw(5'd1, 5'd5); tick();
    drive_add(5'd6, 5'd5, 5'd2); #2;
    rst_n = 1'b0; #1;
    model_reset();
    n_vec++; if (obs !== '0 || bubble_cnt !== 16'd0 || s_cnt !== 2'd0 || load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got %h cnt=%0d scnt=%0d lus=%b want 0", obs, bubble_cnt, s_cnt, load_use_stall); end
    @(negedge clk); rst_n = 1'b1;
    drive_add(5'd3, 5'd5, 5'd2);
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd3 || ex_rs !== 5'd5) begin
      n_err++; $display("FAIL rst_mid_capture: got v=%b wreg=%0d want 1 3", ex_valid, ex_wreg); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive_lw(5'd1, 5'd5); tick();
      drive_add(5'd6, 5'd5, 5'd2); tick(); tick();
    end
    n_vec++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt: got %0d want 3", s_cnt); end
    n_vec++; if (bubble_cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide_cnt: got %0d want 5", bubble_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h05; ops[5] = 6'h08;
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(9) != 0), ops[$urandom_range(5)], 5'($urandom_range(3)),
             5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(2) == 0), 1'($urandom), 1'($urandom));
      flush = ($urandom_range(9) == 0);
      mem_stall = ($urandom_range(6) == 0);
      #1;
      n_vec++; if ({load_use_stall, pc_write, if_id_write} !== {model_lus(), !mem_stall && !model_lus(), !mem_stall && !model_lus()}) begin
        n_err++; $display("FAIL rnd_ctl[%0d]: got %b want %b%b", i, {load_use_stall, pc_write, if_id_write},
                          model_lus(), !mem_stall && !model_lus()); end
      tick();
      n_vec++; if (obs !== m || ex_fw !== model_fw()) begin
        n_err++; $display("FAIL rnd_ex[%0d]: got %h fw=%b want %h fw=%b", i, obs, ex_fw, m, model_fw()); end
      n_vec++; if (bubble_cnt !== 16'(m_cnt) || s_cnt !== 2'(m_cnt2)) begin
        n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bubble_cnt, s_cnt, m_cnt, m_cnt2); end
    end
    flush = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_mem_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
